// File: rtl/result_writeback.sv
// -----------------------------------------------------------------------------
// result_writeback
//
// Writeback stage that sits directly behind the functional units. Every FU
// result is parked in a one-entry holding register, a round-robin arbiter
// picks one full entry per cycle, and the chosen entry is turned into
// registered GPR (two ports), CR-field and MSR write strobes plus the
// architected XER CA/OV/SO state.
//
// Optional feature macro: RESULT_WB_BYPASS_EN
//   defined   -> adds combinational bypass outputs (byp_*, byp_b_*) that show
//                the granted entry in the grant cycle, one cycle ahead of
//                the registered gpr_*_we strobes; zero with no grant.
//   undefined -> bypass ports are absent.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   fub_res[NUM_FUBS]       FU results, .valid marks an offered result
//   fub_tag[NUM_FUBS]       writeback tag:
//                           {addr_a[4:0], wr_a, addr_b[4:0], wr_b,
//                            crf_idx[2:0], wr_cr, wr_ca, wr_ov, wr_msr, rsvd}
//   fub_ready[NUM_FUBS]     holding register i can accept this cycle
//   so_clr                  clear sticky SO (mtxer)
//   gpr_a_we/addr/data      GPR write port A (res_a)
//   gpr_b_we/addr/data      GPR write port B (res_b)
//   cr_we/cr_idx/cr_data    CR field write
//   xer_ca/xer_ov/xer_so    architected XER bits
//   msr_we/msr_data         MSR write
// -----------------------------------------------------------------------------
package result_writeback_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] res_a;
        logic [31:0] res_b;
        logic [3:0]  crf;
        logic [31:0] msr;
        logic        cout;
        logic        ov;
    } result_bus_t;
endpackage

module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int NUM_FUBS = 4,
    parameter int GPR_AW   = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  result_bus_t [NUM_FUBS-1:0]    fub_res,
    input  logic [NUM_FUBS-1:0][19:0]     fub_tag,
    output logic [NUM_FUBS-1:0]           fub_ready,
    input  logic                          so_clr,
    output logic                          gpr_a_we,
    output logic [GPR_AW-1:0]             gpr_a_addr,
    output logic [31:0]                   gpr_a_data,
    output logic                          gpr_b_we,
    output logic [GPR_AW-1:0]             gpr_b_addr,
    output logic [31:0]                   gpr_b_data,
    output logic                          cr_we,
    output logic [2:0]                    cr_idx,
    output logic [3:0]                    cr_data,
    output logic                          xer_ca,
    output logic                          xer_ov,
    output logic                          xer_so,
    output logic                          msr_we,
    output logic [31:0]                   msr_data
`ifdef RESULT_WB_BYPASS_EN
    ,
    output logic                          byp_valid,
    output logic [GPR_AW-1:0]             byp_addr,
    output logic [31:0]                   byp_data,
    output logic                          byp_b_valid,
    output logic [GPR_AW-1:0]             byp_b_addr,
    output logic [31:0]                   byp_b_data
`endif
);

    localparam int RR_W = (NUM_FUBS > 1) ? $clog2(NUM_FUBS) : 1;

    // Holding registers, one per FU input
    logic [NUM_FUBS-1:0] r_hold_valid;
    result_bus_t         r_hold_res [NUM_FUBS];
    logic [19:0]         r_hold_tag [NUM_FUBS];

    // Round-robin pointer: index where the next search starts
    logic [RR_W-1:0]     r_rr;

    // Arbiter results
    logic                w_grant;
    logic [RR_W-1:0]     w_win;
    logic [NUM_FUBS-1:0] w_grant_oh;

    // Decoded view of the granted entry
    result_bus_t         w_sel_res;
    logic [19:0]         w_sel_tag;
    logic [4:0]          w_addr_a;
    logic [4:0]          w_addr_b;
    logic                w_wr_a;
    logic                w_wr_b;
    logic                w_collide;
    logic                w_a_we;
    logic                w_b_we;
    logic                w_cr_we;
    logic                w_ca_we;
    logic                w_ov_we;
    logic                w_msr_we;
    logic                w_so_next;
    logic                w_unused;

    // Round-robin search over full holding registers starting at r_rr
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_grant    = 1'b0;
        w_win      = '0;
        w_grant_oh = '0;
        for (int k = 0; k < NUM_FUBS; k++) begin
            v_idx = int'(r_rr) + k;
            if (v_idx >= NUM_FUBS) begin
                v_idx = v_idx - NUM_FUBS;
            end else begin
                v_idx = v_idx;
            end
            if (!w_grant && r_hold_valid[v_idx]) begin
                w_grant           = 1'b1;
                w_win             = RR_W'(v_idx);
                w_grant_oh[v_idx] = 1'b1;
            end else begin
                w_grant = w_grant;
            end
        end
    end

    // An entry frees up in the same cycle it is granted, so it can refill at once
    assign fub_ready = ~r_hold_valid | w_grant_oh;

    // Decode the granted entry; every strobe is qualified by w_grant so that
    // fields of an idle or untagged entry never produce a write
    always_comb begin
        w_sel_res = r_hold_res[w_win];
        w_sel_tag = r_hold_tag[w_win];
        w_addr_a  = w_sel_tag[19:15];
        w_addr_b  = w_sel_tag[13:9];
        w_wr_a    = w_grant & w_sel_tag[14];
        w_wr_b    = w_grant & w_sel_tag[8];
        // Same destination on both ports: port B carries the surviving value
        w_collide = w_wr_a & w_wr_b & (w_addr_a == w_addr_b);
        w_a_we    = w_wr_a & ~w_collide;
        w_b_we    = w_wr_b;
        w_cr_we   = w_grant & w_sel_tag[4];
        w_ca_we   = w_grant & w_sel_tag[3];
        w_ov_we   = w_grant & w_sel_tag[2];
        w_msr_we  = w_grant & w_sel_tag[1];
        // A same-cycle overflow sets SO even when so_clr is asserted
        w_so_next = (so_clr ? 1'b0 : xer_so) | (w_ov_we & w_sel_res.ov);
        w_unused  = w_sel_res.valid ^ w_sel_tag[0];
    end

    // Holding registers: capture on valid&&ready, release on grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_valid <= '0;
            for (int i = 0; i < NUM_FUBS; i++) begin
                r_hold_res[i] <= '0;
                r_hold_tag[i] <= 20'h0_0000;
            end
        end else begin
            for (int i = 0; i < NUM_FUBS; i++) begin
                if (fub_res[i].valid && fub_ready[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_res[i]   <= fub_res[i];
                    r_hold_tag[i]   <= fub_tag[i];
                end else if (w_grant_oh[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end else begin
                    r_hold_valid[i] <= r_hold_valid[i];
                end
            end
        end
    end

    // Round-robin pointer advances past the winner, unchanged when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr <= '0;
        end else if (w_grant) begin
            if (w_win == RR_W'(NUM_FUBS - 1)) begin
                r_rr <= '0;
            end else begin
                r_rr <= w_win + 1'b1;
            end
        end else begin
            r_rr <= r_rr;
        end
    end

    // Registered write ports; each data field only moves when its strobe fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpr_a_we   <= 1'b0;
            gpr_a_addr <= '0;
            gpr_a_data <= 32'h0000_0000;
            gpr_b_we   <= 1'b0;
            gpr_b_addr <= '0;
            gpr_b_data <= 32'h0000_0000;
            cr_we      <= 1'b0;
            cr_idx     <= 3'b000;
            cr_data    <= 4'h0;
            msr_we     <= 1'b0;
            msr_data   <= 32'h0000_0000;
        end else begin
            gpr_a_we <= w_a_we;
            gpr_b_we <= w_b_we;
            cr_we    <= w_cr_we;
            msr_we   <= w_msr_we;
            if (w_a_we) begin
                gpr_a_addr <= GPR_AW'(w_addr_a);
                gpr_a_data <= w_sel_res.res_a;
            end
            if (w_b_we) begin
                gpr_b_addr <= GPR_AW'(w_addr_b);
                gpr_b_data <= w_sel_res.res_b;
            end
            if (w_cr_we) begin
                cr_idx  <= w_sel_tag[7:5];
                cr_data <= w_sel_res.crf;
            end
            if (w_msr_we) begin
                msr_data <= w_sel_res.msr;
            end
        end
    end

    // Architected XER state: CA/OV follow tagged results, SO is sticky
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xer_ca <= 1'b0;
            xer_ov <= 1'b0;
            xer_so <= 1'b0;
        end else begin
            if (w_ca_we) begin
                xer_ca <= w_sel_res.cout;
            end else begin
                xer_ca <= xer_ca;
            end
            if (w_ov_we) begin
                xer_ov <= w_sel_res.ov;
            end else begin
                xer_ov <= xer_ov;
            end
            xer_so <= w_so_next;
        end
    end

`ifdef RESULT_WB_BYPASS_EN
    // Bypass copies of the granted entry, one cycle ahead of the GPR ports
    always_comb begin
        byp_valid   = w_a_we;
        byp_addr    = w_a_we ? GPR_AW'(w_addr_a) : '0;
        byp_data    = w_a_we ? w_sel_res.res_a : 32'h0000_0000;
        byp_b_valid = w_b_we;
        byp_b_addr  = w_b_we ? GPR_AW'(w_addr_b) : '0;
        byp_b_data  = w_b_we ? w_sel_res.res_b : 32'h0000_0000;
    end
`endif

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;
    import result_writeback_pkg::*;

    localparam int NF = 4;
    localparam int AW = 5;

    logic                    clk = 1'b0;
    logic                    reset_n;
    result_bus_t [NF-1:0]    fub_res;
    logic [NF-1:0][19:0]     fub_tag;
    logic [NF-1:0]           fub_ready;
    logic                    so_clr;
    logic                    gpr_a_we, gpr_b_we, cr_we, msr_we;
    logic [AW-1:0]           gpr_a_addr, gpr_b_addr;
    logic [31:0]             gpr_a_data, gpr_b_data, msr_data;
    logic [2:0]              cr_idx;
    logic [3:0]              cr_data;
    logic                    xer_ca, xer_ov, xer_so;
`ifdef RESULT_WB_BYPASS_EN
    logic                    byp_valid, byp_b_valid;
    logic [AW-1:0]           byp_addr, byp_b_addr;
    logic [31:0]             byp_data, byp_b_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [31:0]   a_data;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [31:0]   b_data;
        logic          cr_we;
        logic [2:0]    cr_idx;
        logic [3:0]    cr_data;
        logic          msr_we;
        logic [31:0]   msr_data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    result_writeback #(.NUM_FUBS(NF), .GPR_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .fub_res(fub_res), .fub_tag(fub_tag),
        .fub_ready(fub_ready), .so_clr(so_clr),
        .gpr_a_we(gpr_a_we), .gpr_a_addr(gpr_a_addr), .gpr_a_data(gpr_a_data),
        .gpr_b_we(gpr_b_we), .gpr_b_addr(gpr_b_addr), .gpr_b_data(gpr_b_data),
        .cr_we(cr_we), .cr_idx(cr_idx), .cr_data(cr_data),
        .xer_ca(xer_ca), .xer_ov(xer_ov), .xer_so(xer_so),
        .msr_we(msr_we), .msr_data(msr_data)
`ifdef RESULT_WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .byp_b_valid(byp_b_valid), .byp_b_addr(byp_b_addr), .byp_b_data(byp_b_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk_tag(input logic [4:0] aa, input logic wa,
                                           input logic [4:0] ab, input logic wb,
                                           input logic [2:0] ci, input logic wc,
                                           input logic wca, input logic wov, input logic wm);
        return {aa, wa, ab, wb, ci, wc, wca, wov, wm, 1'b0};
    endfunction

    function automatic result_bus_t mk_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c, input logic [31:0] m,
                                           input logic co, input logic o);
        result_bus_t r;
        r.valid = 1'b1; r.res_a = a; r.res_b = b; r.crf = c; r.msr = m; r.cout = co; r.ov = o;
        return r;
    endfunction

    // Expected writes for one result: same-address dual write keeps only port B
    function automatic exp_t mk_exp(input result_bus_t r, input logic [19:0] t);
        exp_t e;
        logic col;
        col        = t[14] && t[8] && (t[19:15] == t[13:9]);
        e.a_we     = t[14] && !col;
        e.a_addr   = t[19:15];
        e.a_data   = r.res_a;
        e.b_we     = t[8];
        e.b_addr   = t[13:9];
        e.b_data   = r.res_b;
        e.cr_we    = t[4];
        e.cr_idx   = t[7:5];
        e.cr_data  = r.crf;
        e.msr_we   = t[1];
        e.msr_data = r.msr;
        return e;
    endfunction

    task automatic offer_one(input int idx, input result_bus_t r, input logic [19:0] t);
        fub_res[idx] = r;
        fub_tag[idx] = t;
        sb.push_back(mk_exp(r, t));
        @(posedge clk); #1;
        fub_res[idx].valid = 1'b0;
    endtask

    // Scoreboard: every observed write is popped and compared in order
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (gpr_a_we || gpr_b_we || cr_we || msr_we)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got we(a,b,cr,msr)=%b%b%b%b, required no write",
                         gpr_a_we, gpr_b_we, cr_we, msr_we);
            end else begin
                mon_e = sb.pop_front();
                if ({gpr_a_we, gpr_b_we, cr_we, msr_we} !== {mon_e.a_we, mon_e.b_we, mon_e.cr_we, mon_e.msr_we}
                    || (mon_e.a_we && {gpr_a_addr, gpr_a_data} !== {mon_e.a_addr, mon_e.a_data})
                    || (mon_e.b_we && {gpr_b_addr, gpr_b_data} !== {mon_e.b_addr, mon_e.b_data})
                    || (mon_e.cr_we && {cr_idx, cr_data} !== {mon_e.cr_idx, mon_e.cr_data})
                    || (mon_e.msr_we && msr_data !== mon_e.msr_data)) begin
                    errors++;
                    $display("FAIL sb_write: got we=%b%b%b%b a=%0d/%h b=%0d/%h cr=%0d/%h msr=%h, required we=%b%b%b%b a=%0d/%h b=%0d/%h cr=%0d/%h msr=%h",
                             gpr_a_we, gpr_b_we, cr_we, msr_we, gpr_a_addr, gpr_a_data, gpr_b_addr, gpr_b_data,
                             cr_idx, cr_data, msr_data, mon_e.a_we, mon_e.b_we, mon_e.cr_we, mon_e.msr_we,
                             mon_e.a_addr, mon_e.a_data, mon_e.b_addr, mon_e.b_data, mon_e.cr_idx, mon_e.cr_data,
                             mon_e.msr_data);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; so_clr = 1'b0; fub_res = '0; fub_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gpr_a_we, gpr_b_we, cr_we, msr_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_we: got %b, required 0000", {gpr_a_we, gpr_b_we, cr_we, msr_we});
        end
        checks++;
        if ({xer_ca, xer_ov, xer_so} !== 3'b000) begin
            errors++; $display("FAIL reset_xer: got %b, required 000", {xer_ca, xer_ov, xer_so});
        end
        checks++;
        if (gpr_a_addr !== 5'd0 || gpr_a_data !== 32'h0 || gpr_b_addr !== 5'd0 || gpr_b_data !== 32'h0
            || cr_idx !== 3'd0 || cr_data !== 4'h0 || msr_data !== 32'h0) begin
            errors++; $display("FAIL reset_data: got a=%h b=%h cr=%h msr=%h, required all 0",
                               gpr_a_data, gpr_b_data, cr_data, msr_data);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fub_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_ready: got %b, required 1111", fub_ready);
        end
    endtask

    task automatic test_contention();
        logic [NF-1:0] exp_rdy;
        result_bus_t r;
        logic [19:0] t;
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) begin
            r = mk_res(32'h1000_0000 + 32'(i), 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
            t = mk_tag(5'(i + 1), 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            fub_res[i] = r; fub_tag[i] = t;
            sb.push_back(mk_exp(r, t));
        end
        @(negedge clk);
        checks++;
        if (fub_ready !== 4'b1111) begin
            errors++; $display("FAIL cont_ready_init: got %b, required 1111", fub_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) fub_res[i].valid = 1'b0;
        for (int j = 1; j <= NF; j++) begin
            @(negedge clk);
            exp_rdy = '0;
            for (int i = 0; i < NF; i++) exp_rdy[i] = (i <= j - 1);
            checks++;
            if (fub_ready !== exp_rdy) begin
                errors++; $display("FAIL cont_ready_c%0d: got %b, required %b", j, fub_ready, exp_rdy);
            end
        end
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL cont_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        localparam int NB = 4;
        int na, nb;
        logic ra, rb;
        logic [19:0] ta, tb;
        result_bus_t r;
        @(posedge clk); #1;
        na = 0; nb = 0;
        ta = mk_tag(5'd10, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tb = mk_tag(5'd11, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        r = mk_res(32'hA000_0000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        fub_res[0] = r; fub_tag[0] = ta; sb.push_back(mk_exp(r, ta));
        r = mk_res(32'hB000_0000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        fub_res[1] = r; fub_tag[1] = tb; sb.push_back(mk_exp(r, tb));
        for (int cyc = 0; cyc < 40 && (fub_res[0].valid || fub_res[1].valid); cyc++) begin
            @(negedge clk);
            ra = fub_ready[0]; rb = fub_ready[1];
            @(posedge clk); #1;
            if (fub_res[0].valid && ra) begin
                na++;
                if (na < NB) begin
                    r = mk_res(32'hA000_0000 + 32'(na), 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
                    fub_res[0] = r; sb.push_back(mk_exp(r, ta));
                end else fub_res[0].valid = 1'b0;
            end
            if (fub_res[1].valid && rb) begin
                nb++;
                if (nb < NB) begin
                    r = mk_res(32'hB000_0000 + 32'(nb), 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
                    fub_res[1] = r; sb.push_back(mk_exp(r, tb));
                end else fub_res[1].valid = 1'b0;
            end
        end
        checks++;
        if (na != NB || nb != NB) begin
            errors++; $display("FAIL b2b_accept: got %0d/%0d accepted, required %0d/%0d", na, nb, NB, NB);
        end
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_single();
        result_bus_t r;
        @(posedge clk); #1;
        r = mk_res(32'h1234_5678, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        r.res_b = 32'bx; r.crf = 4'bx; r.msr = 32'bx;
        offer_one(0, r, mk_tag(5'd3, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if (gpr_a_we !== 1'b0) begin
            errors++; $display("FAIL single_early: got gpr_a_we=%b, required 0", gpr_a_we);
        end
`ifdef RESULT_WB_BYPASS_EN
        checks++;
        if (byp_valid !== 1'b1 || byp_addr !== 5'd3 || byp_data !== 32'h1234_5678) begin
            errors++; $display("FAIL single_byp: got %b/%0d/%h, required 1/3/12345678", byp_valid, byp_addr, byp_data);
        end
`endif
        @(negedge clk);
        checks++;
        if (gpr_a_we !== 1'b1 || gpr_a_addr !== 5'd3 || gpr_a_data !== 32'h1234_5678
            || {gpr_b_we, cr_we, msr_we} !== 3'b000) begin
            errors++; $display("FAIL single_write: got we=%b%b%b%b addr=%0d data=%h, required 1000/3/12345678",
                               gpr_a_we, gpr_b_we, cr_we, msr_we, gpr_a_addr, gpr_a_data);
        end
`ifdef RESULT_WB_BYPASS_EN
        checks++;
        if (byp_valid !== 1'b0) begin
            errors++; $display("FAIL single_byp_late: got byp_valid=%b, required 0", byp_valid);
        end
`endif
        @(negedge clk);
        checks++;
        if (gpr_a_we !== 1'b0) begin
            errors++; $display("FAIL single_once: got gpr_a_we=%b, required 0", gpr_a_we);
        end
    endtask

    task automatic test_cr_msr();
        @(posedge clk); #1;
        offer_one(2, mk_res(32'h0000_00A1, 32'h0000_00B2, 4'hA, 32'h8000_1040, 1'b0, 1'b0),
                  mk_tag(5'd1, 1'b1, 5'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cr_we !== 1'b1 || cr_idx !== 3'd5 || cr_data !== 4'hA || msr_we !== 1'b1 || msr_data !== 32'h8000_1040) begin
            errors++; $display("FAIL crmsr_write: got cr=%b/%0d/%h msr=%b/%h, required 1/5/a 1/80001040",
                               cr_we, cr_idx, cr_data, msr_we, msr_data);
        end
        @(negedge clk);
        checks++;
        if (msr_we !== 1'b0 || cr_we !== 1'b0 || msr_data !== 32'h8000_1040 || cr_data !== 4'hA) begin
            errors++; $display("FAIL crmsr_hold: got we=%b%b msr=%h cr=%h, required 00/80001040/a",
                               cr_we, msr_we, msr_data, cr_data);
        end
    endtask

    task automatic test_collision();
        @(posedge clk); #1;
        offer_one(3, mk_res(32'hAAAA_0001, 32'hBBBB_0002, 4'h0, 32'h0, 1'b0, 1'b0),
                  mk_tag(5'd7, 1'b1, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gpr_a_we !== 1'b0 || gpr_b_we !== 1'b1 || gpr_b_addr !== 5'd7 || gpr_b_data !== 32'hBBBB_0002) begin
            errors++; $display("FAIL collision: got a_we=%b b_we=%b b=%0d/%h, required 0/1/7/bbbb0002",
                               gpr_a_we, gpr_b_we, gpr_b_addr, gpr_b_data);
        end
    endtask

    task automatic test_sticky_so();
        logic [19:0] t;
        t = mk_tag(5'd4, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (xer_so !== 1'b0) begin
            errors++; $display("FAIL so_pre: got %b, required 0", xer_so);
        end
        offer_one(1, mk_res(32'h0000_0051, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1), t);
        @(negedge clk); @(negedge clk);
        checks++;
        if ({xer_ca, xer_ov, xer_so} !== 3'b111) begin
            errors++; $display("FAIL so_set: got ca/ov/so=%b, required 111", {xer_ca, xer_ov, xer_so});
        end
        @(posedge clk); #1;
        offer_one(1, mk_res(32'h0000_0052, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0), t);
        @(negedge clk); @(negedge clk);
        checks++;
        if ({xer_ca, xer_ov, xer_so} !== 3'b001) begin
            errors++; $display("FAIL so_keep: got ca/ov/so=%b, required 001", {xer_ca, xer_ov, xer_so});
        end
        @(posedge clk); #1;
        so_clr = 1'b1;
        @(posedge clk); #1;
        so_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (xer_so !== 1'b0) begin
            errors++; $display("FAIL so_clear: got %b, required 0", xer_so);
        end
        @(posedge clk); #1;
        offer_one(1, mk_res(32'h0000_0053, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1), t);
        so_clr = 1'b1;
        @(posedge clk); #1;
        so_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({xer_ov, xer_so} !== 2'b11) begin
            errors++; $display("FAIL so_set_wins: got ov/so=%b, required 11", {xer_ov, xer_so});
        end
    endtask

    task automatic test_reset_mid();
        int wcount;
        result_bus_t r;
        logic [19:0] t;
        @(posedge clk); #1;
        checks++;
        if ({xer_ca, xer_ov, xer_so} !== 3'b111) begin
            errors++; $display("FAIL rmid_pre: got ca/ov/so=%b, required 111", {xer_ca, xer_ov, xer_so});
        end
        for (int i = 0; i < 3; i++) begin
            fub_res[i] = mk_res(32'hDEAD_0000 + 32'(i), 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
            fub_tag[i] = mk_tag(5'(20 + i), 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) fub_res[i].valid = 1'b0;
        checks++;
        if ($countones(fub_ready[2:0]) != 1) begin
            errors++; $display("FAIL rmid_held: got ready=%b, required exactly one of [2:0] set", fub_ready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gpr_a_we, gpr_b_we, cr_we, msr_we} !== 4'b0000 || {xer_ca, xer_ov, xer_so} !== 3'b000) begin
            errors++; $display("FAIL rmid_reset: got we=%b xer=%b, required 0000/000",
                               {gpr_a_we, gpr_b_we, cr_we, msr_we}, {xer_ca, xer_ov, xer_so});
        end
        checks++;
        if (fub_ready !== 4'b1111) begin
            errors++; $display("FAIL rmid_ready: got %b, required 1111", fub_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gpr_a_we || gpr_b_we || cr_we || msr_we) wcount++;
        end
        checks++;
        if (wcount != 0) begin
            errors++; $display("FAIL rmid_nowrite: got %0d write cycles, required 0", wcount);
        end
        // Pointer restarts at 0: FUB0 wins over FUB1 when both arrive together
        @(posedge clk); #1;
        r = mk_res(32'h0000_0E01, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        t = mk_tag(5'd13, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        fub_res[1] = r; fub_tag[1] = t;
        r.res_a = 32'h0000_0E00;
        fub_res[0] = r; fub_tag[0] = t;
        sb.push_back(mk_exp(fub_res[0], t));
        sb.push_back(mk_exp(fub_res[1], t));
        @(posedge clk); #1;
        fub_res[0].valid = 1'b0; fub_res[1].valid = 1'b0;
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rmid_rr_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_back_to_back();
        test_single();
        test_cr_msr();
        test_collision();
        test_sticky_so();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL final_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
